// File: rtl/ad_mem_reader.sv
// Frame-memory read sequencer: issues credit-limited reads against a memory port with
// one cycle of read latency and streams the returned words out with valid/ready and last.
module ad_mem_reader #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic                     reb,
  output logic [ADDRESS_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0]    doutb,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_last
);

  localparam int AW    = ADDRESS_WIDTH;
  localparam int DEPTH = 4;
  localparam logic [AW:0] ONE = (AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state_q;
  logic [AW:0]           issue_cnt_q, issue_cnt_d;
  logic [AW:0]           out_cnt_q, out_cnt_d;
  logic [AW:0]           len_q;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  rd_pend_q;
  logic [1:0]            inflight_q, inflight_d;
  logic [2:0]            fifo_count_q, fifo_count_d;
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] fifo_q [DEPTH];
  logic                  start_ok;
  logic                  push;
  logic                  pop;
  logic                  last_hs;
  logic [3:0]            credit_used;

  assign start_ok    = (state_q == S_IDLE) && start && (length != '0);
  // Outstanding reads count against FIFO space so returning data always has a slot.
  assign credit_used = {1'b0, fifo_count_q} + {2'b00, inflight_q};
  assign reb         = (state_q == S_READ) && (issue_cnt_q != '0) && (credit_used < 4'd4);
  assign addrb       = addr_q;

  assign push    = rd_pend_q;
  assign m_valid = (fifo_count_q != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = m_valid ? fifo_q[rd_ptr_q] : '0;
  assign m_last  = m_valid && (out_cnt_q == (len_q - ONE));
  assign last_hs = pop && m_last;

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  always_comb begin
    issue_cnt_d  = issue_cnt_q;
    addr_d       = addr_q;
    out_cnt_d    = out_cnt_q;
    inflight_d   = inflight_q + {1'b0, reb} - {1'b0, rd_pend_q};
    fifo_count_d = fifo_count_q + {2'b00, push} - {2'b00, pop};
    if (start_ok) begin
      issue_cnt_d = length;
      addr_d      = base_addr;
      out_cnt_d   = '0;
    end else begin
      if (reb) begin
        issue_cnt_d = issue_cnt_q - ONE;
        addr_d      = addr_q + AW'(1);
      end
      if (pop) begin
        out_cnt_d = out_cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_ok) state_q <= S_READ;
        S_READ:  if (reb && (issue_cnt_q == ONE)) state_q <= S_DRAIN;
        S_DRAIN: if (last_hs) state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q  <= '0;
      out_cnt_q    <= '0;
      len_q        <= '0;
      addr_q       <= '0;
      rd_pend_q    <= 1'b0;
      inflight_q   <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      issue_cnt_q  <= issue_cnt_d;
      out_cnt_q    <= out_cnt_d;
      addr_q       <= addr_d;
      rd_pend_q    <= reb;
      inflight_q   <= inflight_d;
      fifo_count_q <= fifo_count_d;
      if (start_ok) len_q <= length;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
    end
  end

  // Storage is datapath only; visibility is governed by the reset count and pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= doutb;
  end

endmodule
